// File: rtl/out_fifo.sv
// out_fifo: byte FIFO between the core's output instruction and the outputbus
// device. The core pushes over a valid/ready handshake; a drain FSM presents
// each byte, strobes out_ready for one cycle, then idles GAP cycles.
// Optional build macro OUT_FIFO_DROP_EN: wr_ready is tied high, pushes into a
// full FIFO are discarded and the sticky overflow flag records the loss.
module out_fifo #(
   parameter int DEPTH = 16,
   parameter int GAP   = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wr_valid,
   input  logic [7:0]             wr_data,
   output logic                   wr_ready,
   output logic [7:0]             out_data,
   output logic                   out_ready,
   output logic [$clog2(DEPTH):0] count,
   output logic                   busy
`ifdef OUT_FIFO_DROP_EN
   ,
   output logic                   overflow
`endif
);

   localparam int AW = $clog2(DEPTH);
   // The gap counter only ever holds GAP-1 down to 0.
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [GW-1:0] GAP_LOAD = GW'(GAP - 1);
   localparam logic [AW:0]   FULL     = (AW + 1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

   state_t        state;
   state_t        state_nxt;
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [GW-1:0] gap_cnt;
   logic          full;
   logic          push;
   logic          pop;
   logic          load;

   assign full = (count == FULL);
   // A full FIFO never accepts, whether it back-pressures or drops.
   assign push = wr_valid && !full;
   // The byte leaves the FIFO during its strobe cycle.
   assign pop  = (state == STROBE);
   assign busy = (count != '0) || (state != IDLE);

`ifdef OUT_FIFO_DROP_EN
   assign wr_ready = 1'b1;

   // Sticky record of the first byte discarded while full.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow <= 1'b0;
      end else if (wr_valid && full) begin
         overflow <= 1'b1;
      end
   end
`else
   assign wr_ready = !full;
`endif

   // Drain FSM next state and outputs; load marks entry into SETUP.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path can
      // leave one unassigned and infer a latch.
      state_nxt = state;
      out_ready = 1'b0;
      load      = 1'b0;
      case (state)
         IDLE: begin
            if (count != '0) begin
               state_nxt = SETUP;
               load      = 1'b1;
            end
         end
         SETUP: state_nxt = STROBE;
         STROBE: begin
            out_ready = 1'b1;
            state_nxt = HOLD;
         end
         HOLD: begin
            if (gap_cnt == '0) begin
               if (count != '0) begin
                  state_nxt = SETUP;
                  load      = 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Drain FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block ordering.
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Storage array; the write port is the only writer.
   always_ff @(posedge clk) begin
      // NOTE: the array has no reset; occupancy and pointers decide which
      // entries are meaningful, so stale contents are never observed.
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers and occupancy; a simultaneous push and pop leaves count alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Output byte is captured on entry to SETUP and held until the next one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data <= '0;
      end else if (load) begin
         out_data <= mem[rd_ptr];
      end
   end

   // Idle gap: loaded during the strobe, counted down through HOLD.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gap_cnt <= '0;
      end else if (state == STROBE) begin
         gap_cnt <= GAP_LOAD;
      end else if ((state == HOLD) && (gap_cnt != '0)) begin
         gap_cnt <= gap_cnt - 1'b1;
      end
   end

endmodule

// File: tb/tb_out_fifo.sv
// tb_out_fifo: directed and random stimulus for out_fifo (DEPTH=4, GAP=2),
// compared every cycle against a timestamp-based model of the drain engine.
module tb_out_fifo;

   localparam int DEPTH = 4;
   localparam int GAP   = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       wr_valid;
   logic [7:0] wr_data;
   logic       wr_ready;
   logic [7:0] out_data;
   logic       out_ready;
   logic [2:0] count;
   logic       busy;
`ifdef OUT_FIFO_DROP_EN
   logic       overflow;
`endif

   out_fifo #(.DEPTH(DEPTH), .GAP(GAP)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_valid  (wr_valid),
      .wr_data   (wr_data),
      .wr_ready  (wr_ready),
      .out_data  (out_data),
      .out_ready (out_ready),
      .count     (count),
      .busy      (busy)
`ifdef OUT_FIFO_DROP_EN
      ,
      .overflow  (overflow)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: contents as a queue, drain engine as edge timestamps.
   // A byte is set up at edge s, strobed between s+1 and s+2, popped at s+2,
   // and the engine may set up the next byte from edge s+2+GAP onward.
   logic [7:0] q[$];
   int         n;
   int         setup_edge;
   int         free_edge;
   logic [7:0] m_out_data;
   logic       m_ovf;

   task automatic model_reset();
      q.delete();
      n          = 0;
      setup_edge = -100;
      free_edge  = 0;
      m_out_data = 8'h00;
      m_ovf      = 1'b0;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, n, obs, exp);
      end
   endtask

   task automatic check_all(input string where);
      logic exp_wr_ready;
`ifdef OUT_FIFO_DROP_EN
      exp_wr_ready = 1'b1;
      check({where, "/overflow"}, 32'(overflow), 32'(m_ovf));
`else
      exp_wr_ready = (q.size() != DEPTH);
`endif
      check({where, "/count"},     32'(count),     32'(q.size()));
      check({where, "/wr_ready"},  32'(wr_ready),  32'(exp_wr_ready));
      check({where, "/out_ready"}, 32'(out_ready), 32'(n == setup_edge + 1));
      check({where, "/out_data"},  32'(out_data),  32'(m_out_data));
      check({where, "/busy"},      32'(busy),      32'((q.size() != 0) || (n < free_edge)));
   endtask

   // One clock: drive inputs, advance the model across the edge, compare.
   task automatic step(input string where, input logic v, input logic [7:0] d,
                       output logic accepted);
      int pre;
      wr_valid = v;
      wr_data  = d;
      pre      = q.size();
      n++;
      accepted = 1'b0;
      if (pre != 0 && n >= free_edge) begin
         setup_edge = n;
         free_edge  = n + 2 + GAP;
         m_out_data = q[0];
      end
      if (n == setup_edge + 2) begin
         void'(q.pop_front());
      end
      if (v && pre != DEPTH) begin
         q.push_back(d);
         accepted = 1'b1;
      end else if (v) begin
         m_ovf = 1'b1;
      end
      @(posedge clk);
      #1;
      check_all(where);
   endtask

   task automatic idle(input string where, input int cycles);
      logic acc;
      for (int i = 0; i < cycles; i++) begin
         step(where, 1'b0, 8'h00, acc);
      end
   endtask

   // Reset asserted mid-cycle; outputs must clear before the next edge.
   task automatic pulse_reset(input string where);
      #2;
      wr_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      model_reset();
      check_all({where, "/during"});
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check_all({where, "/after"});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic acc;
      int   idx;
      int   budget;
      logic [7:0] bytes [6];

      // Reset held with wr_valid high: nothing may be accepted.
      model_reset();
      rst_n    = 1'b0;
      wr_valid = 1'b0;
      wr_data  = 8'h00;
      #2;
      wr_valid = 1'b1;
      wr_data  = 8'h99;
      #1;
      check_all("reset/early");
      repeat (2) @(posedge clk);
      #1;
      check_all("reset/held");
      wr_valid = 1'b0;
      rst_n    = 1'b1;
      check_all("reset/release");

      // Single byte into an empty idle FIFO.
      step("single/push", 1'b1, 8'h41, acc);
      idle("single/drain", 6);

      // Back-pressure: offer 01..06 with wr_valid held until each is taken.
      for (int i = 0; i < 6; i++) bytes[i] = 8'(i + 1);
      idx    = 0;
      budget = 100;
      while (idx < 6 && budget > 0) begin
         step("bp/push", 1'b1, bytes[idx], acc);
         if (acc) idx++;
         budget--;
      end
      check("bp/all_accepted", 32'(idx), 32'd6);
      idle("bp/drain", 30);

      // Wrap-around: ten bytes spaced five cycles apart.
      for (int i = 0; i < 10; i++) begin
         step("wrap/push", 1'b1, 8'hA0 + 8'(i), acc);
         idle("wrap/gap", 4);
      end
      idle("wrap/drain", 10);

      // Reset while strobing with three bytes buffered.
      step("midrst/push", 1'b1, 8'hC1, acc);
      step("midrst/push", 1'b1, 8'hC2, acc);
      step("midrst/push", 1'b1, 8'hC3, acc);
      check("midrst/strobing", 32'(out_ready), 32'd1);
      pulse_reset("midrst");
      step("midrst/new", 1'b1, 8'h55, acc);
      idle("midrst/drain", 8);

`ifdef OUT_FIFO_DROP_EN
      // Drop mode: burst pushes into a draining FIFO.
      for (int i = 0; i < 6; i++) begin
         step("drop/push", 1'b1, 8'(i + 1), acc);
      end
      idle("drop/drain", 30);
      pulse_reset("drop/rst");
`endif

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         step("rand", ($urandom % 3) == 0, 8'($urandom), acc);
      end
      idle("rand/drain", 30);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
